// File: rtl/link_mon_pkg.sv
// Shared types for the link hang monitor.
// FSM state encoding and saturating-counter defaults.
package link_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PKT,
    STARVE,
    HANG
  } link_mon_fsm_t;

  localparam int SAT_W_DEFAULT = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear and parallel load.
// A clear that coincides with an increment leaves the count at one.
module sat_counter
  import link_mon_pkg::*;
#(
  parameter int W = SAT_W_DEFAULT
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc,
  input  logic         clr,
  input  logic         load_en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (load_en) begin
      cnt <= load_val;
    end else if (clr) begin
      cnt <= W'(inc);
    end else if (inc && cnt != MAX) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/link_hang_monitor.sv
// Passive mid-packet starvation watchdog on a credit-based NoC link.
// Define LINK_MON_STATS_EN to build hang_cnt_o and max_starve_o.
module link_hang_monitor
  import link_mon_pkg::*;
#(
  parameter int STALL_THRESHOLD = 64,
  parameter int CNT_W           = 16,
  parameter int HANG_CNT_W      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  tx_i,
  input  logic                  eop_tx_i,
  output logic                  cr_tx_o,
  output logic                  rx_o,
  output logic                  eop_rx_o,
  input  logic                  cr_rx_i,
  input  logic                  clear_i,
  output logic                  hang_o,
  output logic                  hang_start_o,
  output logic                  hang_end_o,
  output logic                  sticky_o,
  output logic [HANG_CNT_W-1:0] hang_cnt_o,
  output logic [CNT_W-1:0]      max_starve_o
);

  localparam logic [CNT_W-1:0] THR = CNT_W'(STALL_THRESHOLD);

  if (STALL_THRESHOLD < 1 ||
      (CNT_W < 31 && STALL_THRESHOLD >= (1 << CNT_W))) begin : g_bad_thr
    $fatal(1, "link_hang_monitor: STALL_THRESHOLD out of range");
  end

  assign cr_tx_o  = cr_rx_i;
  assign rx_o     = tx_i;
  assign eop_rx_o = eop_tx_i;

  link_mon_fsm_t    state;
  logic [CNT_W-1:0] starve_cnt;
  logic             xfer;
  logic             last;
  logic             starve_begin;
  logic             hang_enter;
  logic             interval_end;
  logic             cnt_inc;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;

  always_comb begin
    xfer         = tx_i & cr_rx_i;
    last         = xfer & eop_tx_i;
    starve_begin = (state == PKT) && !tx_i;
    hang_enter   = (state == STARVE) && !tx_i &&
                   (starve_cnt == THR);
    interval_end = ((state == STARVE) || (state == HANG)) && tx_i;
    cnt_inc      = ((state == STARVE) || (state == HANG)) && !tx_i;
    cnt_load     = starve_begin | interval_end;
    cnt_load_val = starve_begin ? CNT_W'(1) : '0;
  end

  // starve_cnt equals the number of low cycles in the current interval
  sat_counter #(
    .W(CNT_W)
  ) u_starve_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc     (cnt_inc),
    .clr     (1'b0),
    .load_en (cnt_load),
    .load_val(cnt_load_val),
    .cnt     (starve_cnt)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      hang_o       <= 1'b0;
      hang_start_o <= 1'b0;
      hang_end_o   <= 1'b0;
      sticky_o     <= 1'b0;
    end else begin
      hang_start_o <= 1'b0;
      hang_end_o   <= 1'b0;
      if (clear_i) sticky_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (xfer && !eop_tx_i) state <= PKT;
        end
        PKT: begin
          if (last) state <= IDLE;
          else if (!tx_i) state <= STARVE;
        end
        STARVE: begin
          if (tx_i) begin
            state <= last ? IDLE : PKT;
          end else if (hang_enter) begin
            state        <= HANG;
            hang_o       <= 1'b1;
            hang_start_o <= 1'b1;
            sticky_o     <= 1'b1;
          end
        end
        HANG: begin
          if (tx_i) begin
            state      <= last ? IDLE : PKT;
            hang_o     <= 1'b0;
            hang_end_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LINK_MON_STATS_EN
  sat_counter #(
    .W(HANG_CNT_W)
  ) u_hang_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc     (hang_enter),
    .clr     (clear_i),
    .load_en (1'b0),
    .load_val('0),
    .cnt     (hang_cnt_o)
  );

  // an interval closing on the clear cycle survives the clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      max_starve_o <= '0;
    end else if (interval_end) begin
      if (clear_i || starve_cnt > max_starve_o)
        max_starve_o <= starve_cnt;
    end else if (clear_i) begin
      max_starve_o <= '0;
    end
  end
`else
  assign hang_cnt_o   = '0;
  assign max_starve_o = '0;
`endif

endmodule
